vga_mem_arbiter: RTL and testbench

- Shares one single-port synchronous image memory (24-bit pixels, 16-bit address) between two requesters.
- Requester 1 is the display pixel-fetch path. It is hard real-time and has fixed priority.
- Requester 2 is a host loader/reader using a req/ack handshake.
- The block sits between the ROM address generator / display pipeline and the image memory, in the clk_25M domain. It registers all memory controls and routes read data back to whichever requester owns each access.

---
 rtl/vga_mem_arbiter.sv | 117 +++++++++++
 tb/tb_vga_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// Shares one single-port image memory between the display fetch path (fixed priority)
// and a host req/ack port. All memory controls are registered; read data is routed by owner tag.
`timescale 1ns/1ps
module vga_mem_arbiter #(
  parameter int DATA_W       = 24,
  parameter int ADDR_W       = 16,
  parameter int BLANK_ONLY   = 1,
  parameter int STARVE_LIMIT = 200
) (
  input  logic              clk_25M,
  input  logic              reset,
  input  logic              active_video,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_starved,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, DISP, HOST} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rd_q, rd_d;
  logic                owner_q, owner_d;
  logic                disp_vld_q, host_vld_q;
  logic [DATA_W-1:0]   disp_hold_q, host_hold_q;
  logic [7:0]          wait_q, wait_d;
  logic                host_ok;

  // A held request is masked during its own ack cycle so it is never granted twice.
  assign host_ok = host_req && (state_q != HOST) &&
                   ((BLANK_ONLY == 0) || !active_video);

  always_comb begin
    state_d     = IDLE;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = 1'b0;
    owner_d     = 1'b0;
    wait_d      = wait_q;
    if (disp_req) begin
      state_d    = DISP;
      mem_addr_d = disp_addr;
      rd_d       = 1'b1;
    end else if (host_ok) begin
      state_d     = HOST;
      mem_we_d    = host_we;
      mem_addr_d  = host_addr;
      mem_wdata_d = host_wdata;
      rd_d        = !host_we;
      owner_d     = 1'b1;
    end
    if (!host_req || state_d == HOST || state_q == HOST)
      wait_d = 8'd0;
    else if (wait_q != 8'hFF)
      wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk_25M or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_q        <= 1'b0;
      owner_q     <= 1'b0;
      disp_vld_q  <= 1'b0;
      host_vld_q  <= 1'b0;
      disp_hold_q <= '0;
      host_hold_q <= '0;
      wait_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      owner_q     <= owner_d;
      disp_vld_q  <= rd_q && !owner_q;
      host_vld_q  <= rd_q && owner_q;
      wait_q      <= wait_d;
      if (disp_vld_q) disp_hold_q <= mem_rdata;
      if (host_vld_q) host_hold_q <= mem_rdata;
    end
  end

  // Return data passes straight through in its valid cycle, then holds until the next one.
  assign disp_valid   = disp_vld_q;
  assign disp_data    = disp_vld_q ? mem_rdata : disp_hold_q;
  assign host_rvalid  = host_vld_q;
  assign host_rdata   = host_vld_q ? mem_rdata : host_hold_q;
  assign host_ack     = (state_q == HOST);
  assign host_starved = (wait_q > LIMIT);
  assign mem_en       = (state_q != IDLE);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: behavioural memory, read-return queues checked per cycle.
`timescale 1ns/1ps
module tb_vga_mem_arbiter;

  logic        clk_25M = 1'b0;
  logic        reset = 1'b0;
  logic        active_video = 1'b0;
  logic        disp_req = 1'b0;
  logic [15:0] disp_addr = '0;
  logic        disp_valid;
  logic [23:0] disp_data;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [23:0] host_wdata = '0;
  logic        host_ack, host_rvalid, host_starved;
  logic [23:0] host_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = '0;

  typedef struct {
    logic [23:0] data;
    int          cyc;
  } exp_t;

  exp_t dq[$];
  exp_t hq[$];
  logic [23:0] mem [0:65535];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  vga_mem_arbiter #(.DATA_W(24), .ADDR_W(16), .BLANK_ONLY(1), .STARVE_LIMIT(200)) dut (
    .clk_25M(clk_25M), .reset(reset), .active_video(active_video),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_starved(host_starved), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #20 clk_25M = ~clk_25M;

  always @(posedge clk_25M) cyc <= cyc + 1;

  function automatic logic [23:0] pat(input int a);
    return 24'(a * 40503) ^ 24'h5A5A5A;
  endfunction

  always @(posedge clk_25M) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_25M);
    #1;
  endtask

  task automatic push_disp(input logic [15:0] a);
    exp_t e;
    e.data = pat(int'(a));
    e.cyc  = cyc + 2;
    dq.push_back(e);
  endtask

  task automatic push_host(input logic [15:0] a);
    exp_t e;
    e.data = pat(int'(a));
    e.cyc  = cyc + 2;
    hq.push_back(e);
  endtask

  always @(negedge clk_25M) begin
    exp_t e;
    if (disp_valid) begin
      if (dq.size() == 0) check("disp_unexpected_valid", 1, 0);
      else begin
        e = dq.pop_front();
        check("disp_data", disp_data, e.data);
        check("disp_cycle", cyc, e.cyc);
      end
    end
    if (host_rvalid) begin
      if (hq.size() == 0) check("host_unexpected_rvalid", 1, 0);
      else begin
        e = hq.pop_front();
        check("host_rdata", host_rdata, e.data);
        check("host_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, intr;
    for (int i = 0; i < 65536; i++) mem[i] = pat(i);

    // reset with requests pending
    disp_req = 1'b1; disp_addr = 16'h0042;
    host_req = 1'b1; host_addr = 16'h0077;
    #1 reset = 1'b1;
    #3;
    check("rst_mem_en", mem_en, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_starved", host_starved, 0);
    repeat (2) step();
    check("rst_hold_mem_en", mem_en, 0);
    check("rst_hold_mem_addr", mem_addr, 0);
    check("rst_hold_disp_data", disp_data, 0);
    disp_req = 1'b0; host_req = 1'b0;
    reset = 1'b0;

    // single display read
    repeat (2) step();
    disp_req = 1'b1; disp_addr = 16'h0010; push_disp(16'h0010);
    step();
    disp_req = 1'b0;
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_we", mem_we, 0);
    check("t1_mem_addr", mem_addr, 16'h0010);
    repeat (3) step();

    // 640 back-to-back display reads
    for (int i = 0; i < 640; i++) begin
      disp_req = 1'b1; disp_addr = 16'(i); push_disp(16'(i));
      step();
    end
    disp_req = 1'b0;
    repeat (3) step();
    check("t2_drained", dq.size(), 0);

    // host write blocked during active video
    active_video = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 24'hABCDEF;
    acks = 0;
    repeat (6) begin
      step();
      if (host_ack) acks++;
    end
    check("t3_no_ack_active", acks, 0);
    active_video = 1'b0;
    step();
    check("t3_ack", host_ack, 1);
    check("t3_mem_en", mem_en, 1);
    check("t3_mem_we", mem_we, 1);
    check("t3_mem_addr", mem_addr, 16'h1234);
    check("t3_mem_wdata", mem_wdata, 24'hABCDEF);
    host_req = 1'b0; host_we = 1'b0;
    step();
    check("t3_ack_pulse", host_ack, 0);
    check("t3_mem_idle", mem_en, 0);
    repeat (2) step();

    // simultaneous display and host read in blanking
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0300;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      disp_req = 1'b1; disp_addr = 16'(16'h0020 + k); push_disp(16'(16'h0020 + k));
      step();
      if (host_ack) acks++;
    end
    check("t4_disp_first", acks, 0);
    disp_req = 1'b0; push_host(16'h0300);
    step();
    check("t4_ack", host_ack, 1);
    check("t4_mem_we", mem_we, 0);
    check("t4_mem_addr", mem_addr, 16'h0300);
    host_req = 1'b0;
    repeat (3) step();

    // starvation under continuous display load
    host_req = 1'b1; host_addr = 16'h0400;
    intr = 0;
    for (int k = 0; k < 250; k++) begin
      if (k == 0 || k == 200 || k == 201 || k == 249)
        check($sformatf("t5_starved_k%0d", k), host_starved, (k > 200) ? 1 : 0);
      disp_req = 1'b1; disp_addr = 16'(1000 + k); push_disp(16'(1000 + k));
      step();
      if (host_ack || !mem_en || mem_we) intr++;
    end
    check("t5_display_uninterrupted", intr, 0);
    disp_req = 1'b0; push_host(16'h0400);
    step();
    check("t5_ack", host_ack, 1);
    check("t5_starved_clear", host_starved, 0);
    host_req = 1'b0;
    repeat (3) step();

    // reset during a host read
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0500;
    step();
    check("t6_ack", host_ack, 1);
    host_req = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_mem_en_drop", mem_en, 0);
    check("t6_ack_drop", host_ack, 0);
    step();
    check("t6_no_rvalid", host_rvalid, 0);
    check("t6_rdata_zero", host_rdata, 0);
    check("t6_mem_addr_zero", mem_addr, 0);
    reset = 1'b0;
    repeat (3) step();

    check("end_disp_queue", dq.size(), 0);
    check("end_host_queue", hq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
